// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the single-bus CPU: fetch T0-T2, per-opcode execute T3-T7, HALT until clear.
// Strobes decode combinationally from state + IR[31:27], one state per clock, no backpressure; define CTRL_MULDIV_EN for mul/div.
module control_unit #(
  parameter logic [4:0] ADD_OP = 5'b00011
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        Run,
  output logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout, In_Portout, Cout, Rout, Baout,
  output logic        PCin, MARin, MDRin, IRin, Yin, Zin_high, Zin_low, HIin, LOin, Rin, ConIn, IncPC,
  output logic        outPortenable,
  output logic        Gra, Grb, Grc,
  output logic        Read, Write,
  output logic [4:0]  operation
);

  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_IMM, C_LDI, C_NEG, C_LD, C_ST, C_BR,
    C_JR, C_JAL, C_MFHI, C_MFLO, C_IN, C_OUT, C_MULDIV, C_HALT
  } cls_t;

  state_t     state_q, state_d, last;
  cls_t       cls;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  always_comb begin
    cls = C_NOP;
    case (opcode)
      5'b00000: cls = C_LD;
      5'b00001: cls = C_LDI;
      5'b00010: cls = C_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: cls = C_ALU;
      5'b01100, 5'b01101, 5'b01110: cls = C_IMM;
`ifdef CTRL_MULDIV_EN
      5'b01111, 5'b10000: cls = C_MULDIV;
`endif
      5'b10001, 5'b10010: cls = C_NEG;
      5'b10011: cls = C_BR;
      5'b10100: cls = C_JR;
      5'b10101: cls = C_JAL;
      5'b10110: cls = C_IN;
      5'b10111: cls = C_OUT;
      5'b11000: cls = C_MFHI;
      5'b11001: cls = C_MFLO;
      5'b11011: cls = C_HALT;
      default:  cls = C_NOP;
    endcase
  end

  // Final execute state of each instruction class; the sequencer returns to T0 after it.
  always_comb begin
    last = T3;
    case (cls)
      C_ALU, C_IMM, C_LDI: last = T5;
      C_NEG, C_JAL:        last = T4;
      C_LD, C_ST:          last = T7;
      C_BR, C_MULDIV:      last = T6;
      default:             last = T3;
    endcase
  end

  always_comb begin
    state_d = T0;
    case (state_q)
      T0:                 state_d = T1;
      T1:                 state_d = T2;
      T2:                 state_d = T3;
      T3, T4, T5, T6: begin
        if (state_q == T3 && cls == C_HALT) state_d = HALT;
        else if (state_q != last)           state_d = state_t'(state_q + 4'd1);
        else                                state_d = T0;
      end
      HALT:               state_d = HALT;
      default:            state_d = T0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (clear) state_q <= T0;
    else       state_q <= state_d;
  end

  always_comb begin
    {PCout, MDRout, Zhighout, Zlowout, HIout, LOout, In_Portout, Cout, Rout, Baout} = '0;
    {PCin, MARin, MDRin, IRin, Yin, Zin_high, Zin_low, HIin, LOin, Rin, ConIn, IncPC} = '0;
    outPortenable = 1'b0;
    {Gra, Grb, Grc, Read, Write} = '0;
    operation = '0;
    Run = (state_q != HALT);
    if (!clear) begin
      case (state_q)
        T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin_low = 1'b1; end
        T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
        T2: begin MDRout = 1'b1; IRin = 1'b1; end
        T3: case (cls)
          C_ALU, C_IMM:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_LDI, C_LD, C_ST: begin Grb = 1'b1; Baout = 1'b1; Yin = 1'b1; end
          C_NEG:  begin Grb = 1'b1; Rout = 1'b1; operation = opcode; Zin_low = 1'b1; end
          C_BR:   begin Gra = 1'b1; Rout = 1'b1; ConIn = 1'b1; end
          C_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          C_JAL:  begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          C_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_IN:   begin In_Portout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_OUT:  begin Gra = 1'b1; Rout = 1'b1; outPortenable = 1'b1; end
`ifdef CTRL_MULDIV_EN
          C_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
`endif
          default: ;
        endcase
        T4: case (cls)
          C_ALU:  begin Grc = 1'b1; Rout = 1'b1; operation = opcode; Zin_low = 1'b1; end
          C_IMM:  begin Cout = 1'b1; operation = opcode; Zin_low = 1'b1; end
          C_LDI, C_LD, C_ST: begin Cout = 1'b1; operation = ADD_OP; Zin_low = 1'b1; end
          C_NEG:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_BR:   begin PCout = 1'b1; Yin = 1'b1; end
          C_JAL:  begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
`ifdef CTRL_MULDIV_EN
          C_MULDIV: begin
            Grb = 1'b1; Rout = 1'b1; operation = opcode; Zin_high = 1'b1; Zin_low = 1'b1;
          end
`endif
          default: ;
        endcase
        T5: case (cls)
          C_ALU, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
          C_BR:       begin Cout = 1'b1; operation = ADD_OP; Zin_low = 1'b1; end
`ifdef CTRL_MULDIV_EN
          C_MULDIV:   begin Zlowout = 1'b1; LOin = 1'b1; end
`endif
          default: ;
        endcase
        T6: case (cls)
          C_LD: begin Read = 1'b1; MDRin = 1'b1; end
          C_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          C_BR: begin Zlowout = 1'b1; PCin = CON_FF; end
`ifdef CTRL_MULDIV_EN
          C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
`endif
          default: ;
        endcase
        T7: case (cls)
          C_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST: Write = 1'b1;
          default: ;
        endcase
        default: ;
      endcase
    end
  end

endmodule
